// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op codes and widths shared by the logic unit pipeline
package logic_unit_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOTA, OP_PASSA
  } op_t;
endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core: combinational bitwise op plus zero/ones/parity reduction
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity
);
  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_NOTA:  y = ~a;
      OP_PASSA: y = a;
      default:  y = '0;
    endcase
  end
  assign zero   = ~|y;
  assign ones   = &y;
  assign parity = ^y;
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: one-deep registered logic unit with accumulator and op counter
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [CNT_W-1:0] ops_done
);
  logic [WIDTH-1:0] acc_reg, b_sel, res;
  logic             res_zero, res_ones, res_parity, in_acc, out_acc;
  assign in_ready = !out_valid || out_ready;
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;
  // a clear in the same cycle as an accumulate beat makes the operand zero
  assign b_sel    = acc ? (acc_clr ? '0 : acc_reg) : b;
  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a(a), .b(b_sel), .op(op_t'(op)),
    .y(res), .zero(res_zero), .ones(res_ones), .parity(res_parity)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
      ones      <= 1'b0;
      parity    <= 1'b0;
      acc_reg   <= '0;
      ops_done  <= '0;
    end else begin
      if (in_acc) begin
        out_valid <= 1'b1;
        y         <= res;
        zero      <= res_zero;
        ones      <= res_ones;
        parity    <= res_parity;
        acc_reg   <= res;
      end else begin
        if (out_acc) out_valid <= 1'b0;
        if (acc_clr) acc_reg <= '0;
      end
      if (out_acc) ops_done <= ops_done + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: vector table, corner sequences and random traffic against a queue model
module tb_logic_unit_pipe;
  localparam int W = 8;
  localparam int CW = 4;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, acc = 0, acc_clr = 0;
  logic out_valid, out_ready = 0, zero, ones, parity;
  logic [W-1:0] a = 0, b = 0, y;
  logic [2:0] op = 0;
  logic [CW-1:0] ops_done;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_acc;
  int m_cnt;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc(acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .zero(zero), .ones(ones), .parity(parity), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [W-1:0] a, b;
    logic acc, clr;
    logic [W-1:0] y;
    logic [2:0] f;
  } vec_t;
  vec_t vec[14];

  function automatic logic [W-1:0] ref_op(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    logic ia, oa;
    logic [W-1:0] r;
    #1;
    chk("in_ready", in_ready, q.size() == 0 || out_ready);
    ia = in_valid && (q.size() == 0 || out_ready);
    oa = q.size() != 0 && out_ready;
    r = ref_op(op, a, acc ? (acc_clr ? '0 : m_acc) : b);
    if (oa) begin
      void'(q.pop_front());
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    if (ia) begin
      q.push_back(r);
      m_acc = r;
    end else if (acc_clr) m_acc = '0;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("y", y, q[0]);
      chk("flags", {zero, ones, parity}, {q[0] == 0, q[0] == '1, ^q[0]});
    end
    chk("ops_done", ops_done, m_cnt);
  endtask

  task automatic do_reset();
    rst = 1;
    in_valid = 0; acc = 0; acc_clr = 0; out_ready = 0;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    m_acc = '0;
    m_cnt = 0;
  endtask

  initial begin
    vec[0]  = '{3'd0, 8'hC3, 8'hA5, 1'b0, 1'b0, 8'h81, 3'b000};
    vec[1]  = '{3'd1, 8'hC3, 8'hA5, 1'b0, 1'b0, 8'hE7, 3'b000};
    vec[2]  = '{3'd2, 8'hC3, 8'hA5, 1'b0, 1'b0, 8'h66, 3'b000};
    vec[3]  = '{3'd3, 8'hC3, 8'hA5, 1'b0, 1'b0, 8'h7E, 3'b000};
    vec[4]  = '{3'd4, 8'hC3, 8'hA5, 1'b0, 1'b0, 8'h18, 3'b000};
    vec[5]  = '{3'd5, 8'hC3, 8'hA5, 1'b0, 1'b0, 8'h99, 3'b000};
    vec[6]  = '{3'd6, 8'hC3, 8'hA5, 1'b0, 1'b0, 8'h3C, 3'b000};
    vec[7]  = '{3'd7, 8'hC3, 8'hA5, 1'b0, 1'b0, 8'hC3, 3'b000};
    vec[8]  = '{3'd2, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h00, 3'b100};
    vec[9]  = '{3'd5, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'hFF, 3'b010};
    vec[10] = '{3'd7, 8'h01, 8'hFE, 1'b0, 1'b0, 8'h01, 3'b001};
    vec[11] = '{3'd1, 8'h01, 8'hFF, 1'b1, 1'b1, 8'h01, 3'b001};
    vec[12] = '{3'd1, 8'h10, 8'hFF, 1'b1, 1'b0, 8'h11, 3'b000};
    vec[13] = '{3'd2, 8'h11, 8'hFF, 1'b1, 1'b0, 8'h00, 3'b100};

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", {zero, ones, parity}, 3'b100);
    chk("rst_ops_done", ops_done, 0);

    out_ready = 1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1; op = vec[i].op; a = vec[i].a; b = vec[i].b;
      acc = vec[i].acc; acc_clr = vec[i].clr;
      cyc();
      chk($sformatf("vec%0d_y", i), y, vec[i].y);
      chk($sformatf("vec%0d_flags", i), {zero, ones, parity}, vec[i].f);
      if (i == 7) begin
        in_valid = 0; acc = 0; acc_clr = 0;
        cyc();
        chk("all_ops_ops_done", ops_done, 8);
      end
    end
    in_valid = 0; acc = 0; acc_clr = 0;
    cyc();

    do_reset();
    out_ready = 1; in_valid = 1; op = 3'd7; a = 8'h11;
    cyc();
    out_ready = 0; a = 8'h22;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_y_held", y, 8'h11);
    end
    out_ready = 1;
    cyc();
    chk("bp_second_y", y, 8'h22);
    in_valid = 0;
    cyc();
    chk("bp_ops_done", ops_done, 2);

    out_ready = 0; in_valid = 1; a = 8'h5C;
    cyc();
    in_valid = 0;
    #3 rst = 1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_zero", zero, 1);
    chk("async_in_ready", in_ready, 1);
    chk("async_ops_done", ops_done, 0);
    do_reset();

    out_ready = 1; in_valid = 1; op = 3'd7;
    for (int i = 0; i < 17; i++) begin
      a = 8'(i);
      cyc();
    end
    in_valid = 0;
    cyc();
    chk("wrap_ops_done", ops_done, 1);

    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      op = 3'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      acc = 1'($urandom);
      acc_clr = 1'($urandom_range(0, 7) == 0);
      cyc();
    end
    in_valid = 0; out_ready = 1; acc = 0; acc_clr = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
